// File: rtl/fetch_pkg.sv
// Types and default widths shared by fetch-0, the fetch queue and decode.
package fetch_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int ILEN_DEFAULT = 32;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] pcPlus4;
        logic                    bPredictedTaken;
        logic [ILEN_DEFAULT-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry queue of fetch entries: synchronous write, combinational head read.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  entry_t                   wdata,
    output entry_t                   rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] head_reg, head_next;
    logic [AW-1:0] tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;

    // Storage has no reset; only pointers and count qualify its contents.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[tail_reg] <= wdata;
        end
    end

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (clear) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (push) tail_next = tail_reg + AW'(1);
            if (pop)  head_next = head_reg + AW'(1);
            case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    assign rdata = mem[head_reg];
    assign count = count_reg;
    assign full  = (count_reg == DEPTH_C);
    assign empty = (count_reg == '0);

endmodule

// File: rtl/fetch_queue.sv
// Fetch-1 queue: tracks the in-flight imem read and buffers up to DEPTH
// {pc, pc+4, prediction, instruction} entries ahead of decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int ILEN  = ILEN_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic                    flush,
    input  logic                    reqValid,
    input  logic [XLEN-1:0]         pcF0,
    input  logic [XLEN-1:0]         pcPlus4F0,
    input  logic                    bPredictedTakenF,
    output logic                    reqReady,
    output logic                    imemOen,
    input  logic [ILEN-1:0]         imemRdata,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [XLEN-1:0]         pc,
    output logic [XLEN-1:0]         pcPlus4,
    output logic                    bPredictedTaken,
    output logic [ILEN-1:0]         instr,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcPlus4;
        logic            bPredictedTaken;
        logic [ILEN-1:0] instr;
    } entry_t;

    logic            pend_valid_reg;
    logic [XLEN-1:0] pend_pc_reg;
    logic [XLEN-1:0] pend_pc4_reg;
    logic            pend_bp_reg;

    logic            accept, push, pop;
    logic            fifo_full, fifo_empty;
    logic [CW:0]     credit_used;
    entry_t          wr_entry, head_entry;

    // The in-flight read holds a slot, so a full-plus-pending queue never
    // receives a push it cannot store.
    assign credit_used = {1'b0, count} + {{CW{1'b0}}, pend_valid_reg};
    assign reqReady    = rstN && !flush && !fifo_full && (credit_used < DEPTH_LIM);
    assign accept      = reqValid && reqReady;
    assign imemOen     = accept;
    assign push        = pend_valid_reg && !flush;
    assign pop         = outValid && outReady && !flush;

    assign wr_entry = '{pc:              pend_pc_reg,
                        pcPlus4:         pend_pc4_reg,
                        bPredictedTaken: pend_bp_reg,
                        instr:           imemRdata};

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pend_valid_reg <= 1'b0;
            pend_pc_reg    <= '0;
            pend_pc4_reg   <= '0;
            pend_bp_reg    <= 1'b0;
        end else begin
            pend_valid_reg <= accept;
            if (accept) begin
                pend_pc_reg  <= pcF0;
                pend_pc4_reg <= pcPlus4F0;
                pend_bp_reg  <= bPredictedTakenF;
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rstN),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head_entry),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign outValid = !fifo_empty;

    always_comb begin
        pc              = '0;
        pcPlus4         = '0;
        bPredictedTaken = 1'b0;
        instr           = '0;
        if (outValid) begin
            pc              = head_entry.pc;
            pcPlus4         = head_entry.pcPlus4;
            bPredictedTaken = head_entry.bPredictedTaken;
            instr           = head_entry.instr;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: each row drives one cycle and checks hand-computed outputs.
module tb_fetch_queue;

    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] MAGIC = 32'hA5A5_0000;

    logic            clk = 1'b0;
    logic            rstN;
    logic            flush;
    logic            reqValid;
    logic [XLEN-1:0] pcF0;
    logic [XLEN-1:0] pcPlus4F0;
    logic            bPredictedTakenF;
    logic            reqReady;
    logic            imemOen;
    logic [ILEN-1:0] imemRdata;
    logic            outValid;
    logic            outReady;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcPlus4;
    logic            bPredictedTaken;
    logic [ILEN-1:0] instr;
    logic [$clog2(DEPTH):0] count;

    int n_vec = 0;
    int n_bad = 0;

    fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rstN             (rstN),
        .flush            (flush),
        .reqValid         (reqValid),
        .pcF0             (pcF0),
        .pcPlus4F0        (pcPlus4F0),
        .bPredictedTakenF (bPredictedTakenF),
        .reqReady         (reqReady),
        .imemOen          (imemOen),
        .imemRdata        (imemRdata),
        .outValid         (outValid),
        .outReady         (outReady),
        .pc               (pc),
        .pcPlus4          (pcPlus4),
        .bPredictedTaken  (bPredictedTaken),
        .instr            (instr),
        .count            (count)
    );

    always #5 clk = ~clk;

    // One-cycle instruction memory: the word at address A is A ^ MAGIC.
    always @(posedge clk) begin
        imemRdata <= imemOen ? (pcF0 ^ MAGIC) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Structural invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (rstN) begin
            chk("count_le_depth", 64'(count <= DEPTH), 64'd1);
            chk("outvalid_eq_nonempty", 64'(outValid), 64'(count != 0));
            if (count == DEPTH) chk("no_accept_when_full", 64'(reqReady), 64'd0);
        end
    end

    task automatic row(input logic rv, input logic [31:0] pci, input logic bpi,
                       input logic ordy, input logic fl,
                       input int ec, input logic erdy, input logic eov,
                       input logic [31:0] epc, input logic ebp);
        logic [31:0] x_pc4, x_ins;
        reqValid         = rv;
        pcF0             = pci;
        pcPlus4F0        = pci + 32'd4;
        bPredictedTakenF = bpi;
        outReady         = ordy;
        flush            = fl;
        x_pc4 = eov ? epc + 32'd4 : 32'd0;
        x_ins = eov ? (epc ^ MAGIC) : 32'd0;
        #1;
        chk("count",    64'(count),           64'(ec));
        chk("reqReady", 64'(reqReady),        64'(erdy));
        chk("imemOen",  64'(imemOen),         64'(rv & erdy));
        chk("outValid", 64'(outValid),        64'(eov));
        chk("pc",       64'(pc),              64'(eov ? epc : 32'd0));
        chk("pcPlus4",  64'(pcPlus4),         64'(x_pc4));
        chk("instr",    64'(instr),           64'(x_ins));
        chk("bpred",    64'(bPredictedTaken), 64'(eov & ebp));
        $display("cyc rv=%0d pcF0=%0h fl=%0d ordy=%0d | cnt=%0d rdy=%0d ov=%0d pc=%0h bp=%0d ins=%0h",
                 rv, pci, fl, ordy, count, reqReady, outValid, pc, bPredictedTaken, instr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN = 1'b0; flush = 1'b0; reqValid = 1'b1; pcF0 = 32'h40;
        pcPlus4F0 = 32'h44; bPredictedTakenF = 1'b1; outReady = 1'b1;
        #2;
        chk("rst_reqReady", 64'(reqReady), 64'd0);
        chk("rst_imemOen",  64'(imemOen),  64'd0);
        chk("rst_outValid", 64'(outValid), 64'd0);
        chk("rst_count",    64'(count),    64'd0);
        chk("rst_pc",       64'(pc),       64'd0);
        reqValid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rstN = 1'b1;
        @(posedge clk);
        #1;

        // Stream: first output two cycles after the first accept, no bubbles.
        //  rv  pcF0   bp ordy fl  cnt rdy ov  head   bp
        row(1, 32'h0, 0, 1, 0,   0, 1, 0, 32'h0, 0);
        row(1, 32'h4, 0, 1, 0,   0, 1, 0, 32'h0, 0);
        row(1, 32'h8, 0, 1, 0,   1, 1, 1, 32'h0, 0);
        row(1, 32'hC, 0, 1, 0,   1, 1, 1, 32'h4, 0);
        row(0, 32'h0, 0, 1, 0,   1, 1, 1, 32'h8, 0);
        row(0, 32'h0, 0, 1, 0,   1, 1, 1, 32'hC, 0);
        row(0, 32'h0, 0, 1, 0,   0, 1, 0, 32'h0, 0);

        // Fill with decode stalled; 0x10 must never be accepted.
        row(1, 32'h0,  0, 0, 0,  0, 1, 0, 32'h0, 0);
        row(1, 32'h4,  0, 0, 0,  0, 1, 0, 32'h0, 0);
        row(1, 32'h8,  0, 0, 0,  1, 1, 1, 32'h0, 0);
        row(1, 32'hC,  0, 0, 0,  2, 1, 1, 32'h0, 0);
        row(1, 32'h10, 0, 0, 0,  3, 0, 1, 32'h0, 0);
        row(1, 32'h10, 0, 0, 0,  4, 0, 1, 32'h0, 0);
        row(1, 32'h10, 0, 0, 0,  4, 0, 1, 32'h0, 0);
        row(0, 32'h0,  0, 1, 0,  4, 0, 1, 32'h0, 0);
        row(0, 32'h0,  0, 1, 0,  3, 1, 1, 32'h4, 0);
        row(0, 32'h0,  0, 1, 0,  2, 1, 1, 32'h8, 0);
        row(0, 32'h0,  0, 1, 0,  1, 1, 1, 32'hC, 0);
        row(0, 32'h0,  0, 1, 0,  0, 1, 0, 32'h0, 0);

        // Flush with 0x100 in flight, flush held two cycles; 0x200 comes out first.
        row(1, 32'h100, 0, 1, 0, 0, 1, 0, 32'h0,   0);
        row(1, 32'h200, 0, 1, 1, 0, 0, 0, 32'h0,   0);
        row(1, 32'h200, 0, 1, 1, 0, 0, 0, 32'h0,   0);
        row(1, 32'h200, 0, 1, 0, 0, 1, 0, 32'h0,   0);
        row(0, 32'h0,   0, 1, 0, 0, 1, 0, 32'h0,   0);
        row(0, 32'h0,   0, 1, 0, 1, 1, 1, 32'h200, 0);
        row(0, 32'h0,   0, 1, 0, 0, 1, 0, 32'h0,   0);

        // Push and pop together from count 3, pointers wrapping.
        row(1, 32'h300, 0, 0, 0, 0, 1, 0, 32'h0,   0);
        row(1, 32'h304, 0, 0, 0, 0, 1, 0, 32'h0,   0);
        row(1, 32'h308, 0, 0, 0, 1, 1, 1, 32'h300, 0);
        row(1, 32'h30C, 0, 0, 0, 2, 1, 1, 32'h300, 0);
        row(1, 32'h310, 0, 1, 0, 3, 0, 1, 32'h300, 0);
        row(1, 32'h310, 0, 1, 0, 3, 1, 1, 32'h304, 0);
        row(1, 32'h314, 0, 1, 0, 2, 1, 1, 32'h308, 0);
        row(1, 32'h318, 0, 1, 0, 2, 1, 1, 32'h30C, 0);
        row(1, 32'h31C, 0, 1, 0, 2, 1, 1, 32'h310, 0);
        row(1, 32'h320, 0, 1, 0, 2, 1, 1, 32'h314, 0);
        row(0, 32'h0,   0, 1, 0, 2, 1, 1, 32'h318, 0);
        row(0, 32'h0,   0, 1, 0, 2, 1, 1, 32'h31C, 0);
        row(0, 32'h0,   0, 1, 0, 1, 1, 1, 32'h320, 0);
        row(0, 32'h0,   0, 1, 0, 0, 1, 0, 32'h0,   0);

        // Asynchronous reset with two entries queued.
        row(1, 32'h500, 0, 0, 0, 0, 1, 0, 32'h0,   0);
        row(1, 32'h504, 0, 0, 0, 0, 1, 0, 32'h0,   0);
        row(0, 32'h0,   0, 0, 0, 1, 1, 1, 32'h500, 0);
        row(0, 32'h0,   0, 0, 0, 2, 1, 1, 32'h500, 0);
        #2 rstN = 1'b0;
        #1;
        chk("arst_outValid", 64'(outValid), 64'd0);
        chk("arst_count",    64'(count),    64'd0);
        chk("arst_pc",       64'(pc),       64'd0);
        chk("arst_instr",    64'(instr),    64'd0);
        chk("arst_reqReady", 64'(reqReady), 64'd0);
        @(posedge clk);
        @(negedge clk) rstN = 1'b1;
        @(posedge clk);
        #1;
        row(0, 32'h0, 0, 1, 0, 0, 1, 0, 32'h0, 0);

        // Prediction bit travels with its PC.
        row(1, 32'h40, 1, 1, 0, 0, 1, 0, 32'h0,  0);
        row(1, 32'h44, 0, 1, 0, 0, 1, 0, 32'h0,  0);
        row(1, 32'h48, 1, 1, 0, 1, 1, 1, 32'h40, 1);
        row(0, 32'h0,  0, 1, 0, 1, 1, 1, 32'h44, 0);
        row(0, 32'h0,  0, 1, 0, 1, 1, 1, 32'h48, 1);
        row(0, 32'h0,  0, 1, 0, 0, 1, 0, 32'h0,  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
